// File: rtl/msrv32_dec.sv
// msrv32_dec: registered RV32I instruction decoder.
// Sits between fetch/immediate generation and the execute/writeback datapath.
// Inputs : clk_in, rst_n_in (async active-low), opcode_in[6:0], funct7_5_in,
//          funct3_in[2:0], iadder_1_to_0_in[1:0], trap_taken_in.
// Outputs: ALU op/operand selects, memory request/size/sign, RF/CSR write
//          enables, writeback and immediate selects, CSR op, illegal and
//          misaligned flags. Every output is registered (one clock latency).
module msrv32_dec (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic [6:0] opcode_in,
  input  logic       funct7_5_in,
  input  logic [2:0] funct3_in,
  input  logic [1:0] iadder_1_to_0_in,
  input  logic       trap_taken_in,
  output logic [3:0] alu_opcode_out,
  output logic       mem_wr_req_out,
  output logic [1:0] load_size_out,
  output logic       load_unsigned_out,
  output logic       alu_src_out,
  output logic       iadder_src_out,
  output logic       csr_wr_en_out,
  output logic       rf_wr_en_out,
  output logic [2:0] wb_mux_sel_out,
  output logic [2:0] imm_type_out,
  output logic [2:0] csr_op_out,
  output logic       illegal_instr_out,
  output logic       misaligned_load_out,
  output logic       misaligned_store_out
);

  // Opcode classes, keyed on opcode_in[6:2].
  localparam logic [4:0] OpcOp     = 5'b01100;
  localparam logic [4:0] OpcOpImm  = 5'b00100;
  localparam logic [4:0] OpcLoad   = 5'b00000;
  localparam logic [4:0] OpcStore  = 5'b01000;
  localparam logic [4:0] OpcBranch = 5'b11000;
  localparam logic [4:0] OpcJal    = 5'b11011;
  localparam logic [4:0] OpcJalr   = 5'b11001;
  localparam logic [4:0] OpcLui    = 5'b01101;
  localparam logic [4:0] OpcAuipc  = 5'b00101;
  localparam logic [4:0] OpcMisc   = 5'b00011;
  localparam logic [4:0] OpcSystem = 5'b11100;

  logic w_op, w_op_imm, w_load, w_store, w_branch, w_jal, w_jalr;
  logic w_lui, w_auipc, w_misc, w_system, w_csr, w_illegal;
  logic w_misaligned;
  logic [3:0] w_alu_opcode;
  logic [2:0] w_wb_sel, w_imm_type;

  always_comb begin
    w_op     = 1'b0;
    w_op_imm = 1'b0;
    w_load   = 1'b0;
    w_store  = 1'b0;
    w_branch = 1'b0;
    w_jal    = 1'b0;
    w_jalr   = 1'b0;
    w_lui    = 1'b0;
    w_auipc  = 1'b0;
    w_misc   = 1'b0;
    w_system = 1'b0;
    // Classes only exist for 32-bit encodings (low bits 11).
    if (opcode_in[1:0] == 2'b11) begin
      case (opcode_in[6:2])
        OpcOp:     w_op     = 1'b1;
        OpcOpImm:  w_op_imm = 1'b1;
        OpcLoad:   w_load   = 1'b1;
        OpcStore:  w_store  = 1'b1;
        OpcBranch: w_branch = 1'b1;
        OpcJal:    w_jal    = 1'b1;
        OpcJalr:   w_jalr   = 1'b1;
        OpcLui:    w_lui    = 1'b1;
        OpcAuipc:  w_auipc  = 1'b1;
        OpcMisc:   w_misc   = 1'b1;
        OpcSystem: w_system = 1'b1;
        default:   ;
      endcase
    end
    w_csr     = w_system & (funct3_in != 3'b000);
    w_illegal = ~(w_op | w_op_imm | w_load | w_store | w_branch | w_jal | w_jalr |
                  w_lui | w_auipc | w_misc | w_system);

    // Half needs bit 0 clear, word needs both low bits clear.
    w_misaligned = ((funct3_in[1:0] == 2'b01) & iadder_1_to_0_in[0]) |
                   ((funct3_in[1:0] == 2'b10) & (iadder_1_to_0_in != 2'b00));

    w_alu_opcode = 4'b0000;
    if (w_op) begin
      w_alu_opcode = {funct7_5_in, funct3_in};
    end else if (w_op_imm) begin
      // Only SRLI/SRAI carry the alternate bit; for other immediates it is imm data.
      w_alu_opcode = {funct7_5_in & (funct3_in == 3'b101), funct3_in};
    end

    w_wb_sel = 3'b000;
    if (w_load)             w_wb_sel = 3'b001;
    else if (w_lui)         w_wb_sel = 3'b010;
    else if (w_auipc)       w_wb_sel = 3'b011;
    else if (w_csr)         w_wb_sel = 3'b100;
    else if (w_jal | w_jalr) w_wb_sel = 3'b101;

    w_imm_type = 3'b000;
    if (w_op_imm | w_load | w_jalr) w_imm_type = 3'b001;
    else if (w_store)               w_imm_type = 3'b010;
    else if (w_branch)              w_imm_type = 3'b011;
    else if (w_lui | w_auipc)       w_imm_type = 3'b100;
    else if (w_jal)                 w_imm_type = 3'b101;
    else if (w_csr)                 w_imm_type = 3'b110;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      alu_opcode_out       <= 4'b0000;
      mem_wr_req_out       <= 1'b0;
      load_size_out        <= 2'b00;
      load_unsigned_out    <= 1'b0;
      alu_src_out          <= 1'b0;
      iadder_src_out       <= 1'b0;
      csr_wr_en_out        <= 1'b0;
      rf_wr_en_out         <= 1'b0;
      wb_mux_sel_out       <= 3'b000;
      imm_type_out         <= 3'b000;
      csr_op_out           <= 3'b000;
      illegal_instr_out    <= 1'b0;
      misaligned_load_out  <= 1'b0;
      misaligned_store_out <= 1'b0;
    end else begin
      alu_opcode_out       <= w_alu_opcode;
      mem_wr_req_out       <= w_store & ~w_misaligned & ~trap_taken_in;
      load_size_out        <= funct3_in[1:0];
      load_unsigned_out    <= funct3_in[2];
      alu_src_out          <= opcode_in[5];
      iadder_src_out       <= w_load | w_store | w_jalr;
      csr_wr_en_out        <= w_csr;
      rf_wr_en_out         <= w_op | w_op_imm | w_load | w_lui | w_auipc | w_jal | w_jalr |
                              w_csr;
      wb_mux_sel_out       <= w_wb_sel;
      imm_type_out         <= w_imm_type;
      csr_op_out           <= w_system ? funct3_in : 3'b000;
      illegal_instr_out    <= w_illegal;
      misaligned_load_out  <= w_load & w_misaligned;
      misaligned_store_out <= w_store & w_misaligned;
    end
  end

endmodule

// File: tb/tb_msrv32_dec.sv
// Self-checking bench for msrv32_dec: directed test-plan steps plus random
// instructions compared against an instruction-level reference model.
module tb_msrv32_dec;

  logic       clk_in = 1'b0;
  logic       rst_n_in;
  logic [6:0] opcode_in;
  logic       funct7_5_in;
  logic [2:0] funct3_in;
  logic [1:0] iadder_1_to_0_in;
  logic       trap_taken_in;
  logic [3:0] alu_opcode_out;
  logic       mem_wr_req_out;
  logic [1:0] load_size_out;
  logic       load_unsigned_out;
  logic       alu_src_out;
  logic       iadder_src_out;
  logic       csr_wr_en_out;
  logic       rf_wr_en_out;
  logic [2:0] wb_mux_sel_out;
  logic [2:0] imm_type_out;
  logic [2:0] csr_op_out;
  logic       illegal_instr_out;
  logic       misaligned_load_out;
  logic       misaligned_store_out;

  int checks = 0;
  int errors = 0;

  msrv32_dec dut (
    .clk_in               (clk_in),
    .rst_n_in             (rst_n_in),
    .opcode_in            (opcode_in),
    .funct7_5_in          (funct7_5_in),
    .funct3_in            (funct3_in),
    .iadder_1_to_0_in     (iadder_1_to_0_in),
    .trap_taken_in        (trap_taken_in),
    .alu_opcode_out       (alu_opcode_out),
    .mem_wr_req_out       (mem_wr_req_out),
    .load_size_out        (load_size_out),
    .load_unsigned_out    (load_unsigned_out),
    .alu_src_out          (alu_src_out),
    .iadder_src_out       (iadder_src_out),
    .csr_wr_en_out        (csr_wr_en_out),
    .rf_wr_en_out         (rf_wr_en_out),
    .wb_mux_sel_out       (wb_mux_sel_out),
    .imm_type_out         (imm_type_out),
    .csr_op_out           (csr_op_out),
    .illegal_instr_out    (illegal_instr_out),
    .misaligned_load_out  (misaligned_load_out),
    .misaligned_store_out (misaligned_store_out)
  );

  always #5 clk_in = ~clk_in;

  // Packed view: {alu_op4, mem_wr, ld_size2, ld_uns, alu_src, iadd_src, csr_we, rf_we,
  //               wb3, imm3, csr_op3, illegal, mis_ld, mis_st}
  function automatic logic [23:0] dut_vec();
    return {alu_opcode_out, mem_wr_req_out, load_size_out, load_unsigned_out, alu_src_out,
            iadder_src_out, csr_wr_en_out, rf_wr_en_out, wb_mux_sel_out, imm_type_out,
            csr_op_out, illegal_instr_out, misaligned_load_out, misaligned_store_out};
  endfunction

  typedef enum int {KOp, KOpImm, KLoad, KStore, KBranch, KJal, KJalr, KLui, KAuipc,
                    KFence, KSystem, KIllegal} kind_t;

  // Reference: classify the whole 7-bit opcode, then apply per-instruction rules.
  function automatic logic [23:0] model(input logic [6:0] op, input logic f7,
                                        input logic [2:0] f3, input logic [1:0] iad,
                                        input logic trap);
    kind_t k;
    int bytes;
    logic mis, csr;
    logic [3:0] alu;
    logic [2:0] wb, imm, cop;
    logic rf, isrc, msel;
    case (op)
      7'h33:   k = KOp;
      7'h13:   k = KOpImm;
      7'h03:   k = KLoad;
      7'h23:   k = KStore;
      7'h63:   k = KBranch;
      7'h6F:   k = KJal;
      7'h67:   k = KJalr;
      7'h37:   k = KLui;
      7'h17:   k = KAuipc;
      7'h0F:   k = KFence;
      7'h73:   k = KSystem;
      default: k = KIllegal;
    endcase
    bytes = 1 << f3[1:0];
    mis   = (f3[1:0] != 2'b11) && ((int'(iad) % bytes) != 0);
    msel  = (k == KLoad) || (k == KStore);
    csr   = (k == KSystem) && (f3 != 3'd0);
    alu   = 4'd0;
    if (k == KOp) alu = {f7, f3};
    if (k == KOpImm) alu = {(f3 == 3'd5) ? f7 : 1'b0, f3};
    wb = 3'd0; imm = 3'd0;
    case (k)
      KLoad:   begin wb = 3'd1; imm = 3'd1; end
      KOpImm:  imm = 3'd1;
      KJalr:   begin wb = 3'd5; imm = 3'd1; end
      KStore:  imm = 3'd2;
      KBranch: imm = 3'd3;
      KLui:    begin wb = 3'd2; imm = 3'd4; end
      KAuipc:  begin wb = 3'd3; imm = 3'd4; end
      KJal:    begin wb = 3'd5; imm = 3'd5; end
      default: ;
    endcase
    if (csr) begin wb = 3'd4; imm = 3'd6; end
    rf   = (k inside {KOp, KOpImm, KLoad, KLui, KAuipc, KJal, KJalr}) || csr;
    isrc = msel || (k == KJalr);
    cop  = (k == KSystem) ? f3 : 3'd0;
    return {alu, (k == KStore) && !mis && !trap, f3[1:0], f3[2], op[5], isrc, csr, rf, wb,
            imm, cop, k == KIllegal, (k == KLoad) && mis, (k == KStore) && mis};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Apply inputs while clock is low, capture on posedge, sample 1ns later.
  task automatic step(input logic [6:0] op, input logic f7, input logic [2:0] f3,
                      input logic [1:0] iad, input logic trap, input string tag);
    opcode_in = op; funct7_5_in = f7; funct3_in = f3;
    iadder_1_to_0_in = iad; trap_taken_in = trap;
    @(posedge clk_in); #1;
    chk(tag, {8'd0, dut_vec()}, {8'd0, model(op, f7, f3, iad, trap)});
    @(negedge clk_in);
  endtask

  localparam logic [6:0] LegalOps [11] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67,
                                           7'h37, 7'h17, 7'h0F, 7'h73};

  initial begin
    rst_n_in = 1'b0;
    opcode_in = 7'h33; funct7_5_in = 1'b1; funct3_in = 3'd7;
    iadder_1_to_0_in = 2'd3; trap_taken_in = 1'b0;
    @(posedge clk_in); @(negedge clk_in);
    chk("reset_zero", {8'd0, dut_vec()}, 32'd0);
    rst_n_in = 1'b1;

    step(7'b0110011, 1'b0, 3'b000, 2'b00, 1'b0, "add");
    chk("add_alu", {28'd0, alu_opcode_out}, 32'd0);
    chk("add_rf_src", {30'd0, rf_wr_en_out, alu_src_out}, 32'd3);
    step(7'b0110000, 1'b0, 3'b000, 2'b00, 1'b0, "ill_low");
    chk("ill_low_flags", {29'd0, illegal_instr_out, rf_wr_en_out, mem_wr_req_out}, 32'd4);
    step(7'b0100000, 1'b0, 3'b010, 2'b10, 1'b0, "ill_store");
    chk("ill_store_flags", {29'd0, illegal_instr_out, misaligned_store_out, mem_wr_req_out},
        32'd4);
    step(7'b0100011, 1'b0, 3'b010, 2'b10, 1'b0, "sw_mis");
    chk("sw_mis_flags", {30'd0, misaligned_store_out, mem_wr_req_out}, 32'd2);
    step(7'b0100011, 1'b0, 3'b010, 2'b00, 1'b0, "sw_ok");
    chk("sw_ok_flags", {28'd0, mem_wr_req_out, imm_type_out}, 32'hA);
    step(7'b0100011, 1'b0, 3'b010, 2'b00, 1'b1, "sw_trap");
    chk("sw_trap_req", {31'd0, mem_wr_req_out}, 32'd0);
    step(7'b0000011, 1'b0, 3'b101, 2'b01, 1'b0, "lhu_mis");
    chk("lhu_flags", {25'd0, misaligned_load_out, load_size_out, load_unsigned_out,
                      wb_mux_sel_out}, 32'h59);
    step(7'b0010011, 1'b1, 3'b101, 2'b00, 1'b0, "srai");
    chk("srai_alu", {27'd0, alu_opcode_out, alu_src_out}, 32'h1A);
    step(7'b0010011, 1'b1, 3'b000, 2'b00, 1'b0, "addi_f7");
    chk("addi_alu", {28'd0, alu_opcode_out}, 32'd0);
    step(7'b1101111, 1'b0, 3'b000, 2'b00, 1'b0, "jal");
    chk("jal_sel", {26'd0, wb_mux_sel_out, imm_type_out}, 32'o55);
    step(7'b1110011, 1'b0, 3'b001, 2'b00, 1'b0, "csrrw");
    chk("csrrw_flags", {25'd0, csr_wr_en_out, csr_op_out, wb_mux_sel_out}, 32'h4C);
    step(7'b0000011, 1'b0, 3'b010, 2'b11, 1'b0, "lw_mis");
    step(7'b0000011, 1'b0, 3'b000, 2'b11, 1'b0, "lb_any");

    // Asynchronous reset: clears mid-cycle without a clock edge.
    #1 rst_n_in = 1'b0;
    #1 chk("async_reset", {8'd0, dut_vec()}, 32'd0);
    @(negedge clk_in); rst_n_in = 1'b1;

    for (int i = 0; i < 400; i++) begin
      logic [6:0] op;
      op = ($urandom_range(0, 3) == 0) ? 7'($urandom) : LegalOps[$urandom_range(0, 10)];
      step(op, 1'($urandom), 3'($urandom), 2'($urandom), ($urandom_range(0, 3) == 0),
           "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/msrv32_dec.md
Name: msrv32_dec

Overview:
- Registered instruction decoder for the msrv32 RV32I core, placed between instruction fetch/immediate generation and the execute/writeback datapath.
- Decodes opcode, funct3 and funct7[5] into ALU, memory, register-file, CSR and writeback controls.
- Flags illegal opcodes and misaligned load/store addresses.
- All outputs are registered: one clock of latency.

Parameters:
- none

Ports:
- clk_in  input  1  system clock, rising edge
- rst_n_in  input  1  asynchronous active-low reset
- opcode_in  input  7  instruction[6:0]
- funct7_5_in  input  1  instruction[30]
- funct3_in  input  3  instruction[14:12]
- iadder_1_to_0_in  input  2  low bits of computed load/store address
- trap_taken_in  input  1  trap being taken this cycle
- alu_opcode_out  output  4  {alt-bit, funct3} ALU operation
- mem_wr_req_out  output  1  store request
- load_size_out  output  2  00 byte, 01 half, 10 word
- load_unsigned_out  output  1  zero-extend load
- alu_src_out  output  1  1 = rs2, 0 = immediate
- iadder_src_out  output  1  1 = rs1 base, 0 = PC base
- csr_wr_en_out  output  1  CSR write enable
- rf_wr_en_out  output  1  register-file write enable
- wb_mux_sel_out  output  3  writeback source select
- imm_type_out  output  3  immediate format
- csr_op_out  output  3  CSR operation (funct3)
- illegal_instr_out  output  1  illegal instruction
- misaligned_load_out  output  1  misaligned load
- misaligned_store_out  output  1  misaligned store

Behaviour:
- Reset: while rst_n_in=0 (asynchronous assert), every output = 0. Outputs update on the first rising clk_in after release.
- Latency: each output register captures the combinational decode of the current inputs on every rising clk_in. No enable and no handshake.

Opcode classes:
- Valid only when opcode_in[1:0]=11. Class is selected by opcode_in[6:2]:
- 01100 OP, 00100 OP-IMM, 00000 LOAD, 01000 STORE, 11000 BRANCH
- 11011 JAL, 11001 JALR, 01101 LUI, 00101 AUIPC, 00011 MISC-MEM
- 11100 SYSTEM: CSR when funct3≠000
- illegal_instr_out = 1 when opcode_in[1:0]≠11 or opcode_in[6:2] matches no class. An illegal instruction forces rf_wr_en, csr_wr_en, mem_wr_req and both misaligned flags to 0.

ALU and operand select:
- alu_opcode_out[2:0] = funct3_in for OP and OP-IMM; otherwise 000 (ADD).
- alu_opcode_out[3] = funct7_5_in for OP, and for OP-IMM only when funct3=101; otherwise 0.
- alu_src_out = opcode_in[5].
- iadder_src_out = 1 for LOAD/STORE/JALR, else 0.

Memory:
- load_size_out = funct3_in[1:0].
- load_unsigned_out = funct3_in[2].
- Misalignment applies to LOAD (misaligned_load_out) and STORE (misaligned_store_out). A flag is 1 when the access is half with iadder[0]=1, or word with iadder[1:0]≠00.
- mem_wr_req_out = STORE & ~misaligned_store & ~trap_taken_in.

Register file and CSR:
- rf_wr_en_out = 1 for OP, OP-IMM, LOAD, LUI, AUIPC, JAL, JALR, CSR.
- csr_wr_en_out = 1 for CSR.
- csr_op_out = funct3_in for SYSTEM, else 000.

Writeback select (wb_mux_sel_out):
- 000 ALU (default)
- 001 load data
- 010 U-immediate (LUI)
- 011 iadder (AUIPC)
- 100 CSR data
- 101 PC+4 (JAL/JALR)

Immediate format (imm_type_out):
- 000 none/R
- 001 I (OP-IMM, LOAD, JALR)
- 010 S
- 011 B
- 100 U (LUI/AUIPC)
- 101 J
- 110 CSR zimm

Test Plan:
1. Reset low → all outputs 0. Release and clock opcode 0110011, f3=000, f7_5=0 (ADD) → alu_opcode=0000, rf_wr_en=1, alu_src=1, wb_sel=000, illegal=0.
2. Opcode 0110000 (low bits 00) → after one clock illegal=1, rf_wr_en=0, mem_wr_req=0.
3. Opcode 0100000, iadder=10 (low bits 00) → illegal=1, misaligned_store=0, mem_wr_req=0.
4. STORE 0100011:
   - f3=010, iadder=10 → misaligned_store=1, mem_wr_req=0.
   - iadder=00 → mem_wr_req=1, imm_type=010.
   - trap_taken=1 → mem_wr_req=0.
5. LOAD 0000011:
   - f3=101, iadder=01 → misaligned_load=1, load_size=01, load_unsigned=1, wb_sel=001.
   - OP-IMM f3=101, f7_5=1 (SRAI) → alu_opcode=1101, alu_src=0.
6. Control flow and CSR:
   - JAL 1101111 → wb_sel=101, imm_type=101.
   - CSRRW 1110011, f3=001 → csr_wr_en=1, csr_op=001, wb_sel=100.
   - Assert reset mid-stream → outputs clear immediately, no clock needed.
